// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 single-byte full-duplex master, MSB first.
// Every output is a flop; the FSM computes next values and one register bank holds them.
module spi_master #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              scl,
  output logic              mosi,
  input  logic              miso,
  output logic              cs
);

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    HIGH,
    LOW,
    TAIL
  } state_t;

  localparam int              BIT_W    = $clog2(DATA_W);
  localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  state_t              state, state_nxt;
  logic [7:0]          div_cnt, div_cnt_nxt;
  logic [BIT_W-1:0]    bit_cnt, bit_cnt_nxt;
  logic [DATA_W-1:0]   tx_shift, tx_shift_nxt;
  logic [DATA_W-1:0]   rx_shift, rx_shift_nxt;
  logic [DATA_W-1:0]   rx_data_nxt;
  logic                busy_nxt, done_nxt, scl_nxt, mosi_nxt, cs_nxt;
  logic                div_end;

  assign div_end = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      scl      <= 1'b0;
      mosi     <= 1'b0;
      cs       <= 1'b1;
    end else begin
      state    <= state_nxt;
      div_cnt  <= div_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      tx_shift <= tx_shift_nxt;
      rx_shift <= rx_shift_nxt;
      rx_data  <= rx_data_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      scl      <= scl_nxt;
      mosi     <= mosi_nxt;
      cs       <= cs_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    div_cnt_nxt  = div_cnt;
    bit_cnt_nxt  = bit_cnt;
    tx_shift_nxt = tx_shift;
    rx_shift_nxt = rx_shift;
    rx_data_nxt  = rx_data;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    scl_nxt      = scl;
    mosi_nxt     = mosi;
    cs_nxt       = cs;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt    = LEAD;
          tx_shift_nxt = tx_data;
          bit_cnt_nxt  = '0;
          div_cnt_nxt  = '0;
          cs_nxt       = 1'b0;
          busy_nxt     = 1'b1;
          mosi_nxt     = tx_data[DATA_W-1];
        end
      end

      LEAD, LOW: begin
        // Rising scl edge: miso has been stable for the whole preceding low phase.
        if (div_end) begin
          state_nxt    = HIGH;
          div_cnt_nxt  = '0;
          scl_nxt      = 1'b1;
          rx_shift_nxt = {rx_shift[DATA_W-2:0], miso};
        end else begin
          div_cnt_nxt = div_cnt + 8'd1;
        end
      end

      HIGH: begin
        if (div_end) begin
          div_cnt_nxt = '0;
          scl_nxt     = 1'b0;
          if (bit_cnt == BIT_LAST) begin
            state_nxt = TAIL;
          end else begin
            state_nxt    = LOW;
            bit_cnt_nxt  = bit_cnt + 1'b1;
            tx_shift_nxt = {tx_shift[DATA_W-2:0], 1'b0};
            mosi_nxt     = tx_shift[DATA_W-2];
          end
        end else begin
          div_cnt_nxt = div_cnt + 8'd1;
        end
      end

      TAIL: begin
        if (div_end) begin
          state_nxt   = IDLE;
          div_cnt_nxt = '0;
          cs_nxt      = 1'b1;
          busy_nxt    = 1'b0;
          done_nxt    = 1'b1;
          mosi_nxt    = 1'b0;
          rx_data_nxt = rx_shift;
        end else begin
          div_cnt_nxt = div_cnt + 8'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed bench for spi_master with a mode-0 slave model.
// Two instances (CLK_DIV=2 and CLK_DIV=1); sel picks which one is driven and observed.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sel = 1'b0;
  bit         loop = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] slv_byte = 8'h00;
  logic [7:0] slv_sh = 8'h00;
  logic       slv_bit = 1'bx;
  logic       miso;

  logic [7:0] rx0, rx1;
  logic       busy0, busy1, done0, done1, scl0, scl1, mosi0, mosi1, cs0, cs1;
  logic [7:0] m_rx;
  logic       m_busy, m_done, m_scl, m_mosi, m_cs;

  spi_master #(.DATA_W(8), .CLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .start(start & ~sel), .tx_data(tx_data), .rx_data(rx0),
    .busy(busy0), .done(done0), .scl(scl0), .mosi(mosi0), .miso(miso), .cs(cs0)
  );

  spi_master #(.DATA_W(8), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start & sel), .tx_data(tx_data), .rx_data(rx1),
    .busy(busy1), .done(done1), .scl(scl1), .mosi(mosi1), .miso(miso), .cs(cs1)
  );

  assign m_rx   = sel ? rx1   : rx0;
  assign m_busy = sel ? busy1 : busy0;
  assign m_done = sel ? done1 : done0;
  assign m_scl  = sel ? scl1  : scl0;
  assign m_mosi = sel ? mosi1 : mosi0;
  assign m_cs   = sel ? cs1   : cs0;
  assign miso   = loop ? m_mosi : slv_bit;

  always #5 clk = ~clk;

  // Slave: first bit on cs fall, next bit on each scl fall, X while deselected.
  logic cs_q = 1'b1, scl_q = 1'b0;
  always @(m_cs or m_scl) begin
    if (m_cs !== 1'b0) begin
      slv_bit = 1'bx;
      cs_q    = 1'b1;
      scl_q   = m_scl;
    end else if (cs_q) begin
      slv_sh  = slv_byte;
      slv_bit = slv_sh[7];
      cs_q    = 1'b0;
      scl_q   = m_scl;
    end else if (scl_q && !m_scl) begin
      slv_sh  = {slv_sh[6:0], 1'b0};
      slv_bit = slv_sh[7];
      scl_q   = 1'b0;
    end else begin
      scl_q = m_scl;
    end
  end

  int         total_rises = 0, total_done = 0, xfer_rises = 0;
  int         cur_low = 0, cur_high = 0, last_low = 0, last_high = 0, first_gap = 0;
  logic [7:0] cap = 8'h00;
  logic       prev_cs = 1'b1, prev_scl = 1'b0;

  always @(negedge clk) begin
    if (prev_cs === 1'b1 && m_cs === 1'b0) begin
      last_high  = cur_high;
      cur_low    = 0;
      xfer_rises = 0;
    end
    if (prev_cs === 1'b0 && m_cs === 1'b1) last_low = cur_low;
    if (m_scl === 1'b1 && prev_scl === 1'b0) begin
      if (xfer_rises == 0) first_gap = cur_low;
      xfer_rises++;
      total_rises++;
      cap = {cap[6:0], m_mosi};
    end
    if (m_cs === 1'b0) cur_low++;
    if (m_cs === 1'b1) cur_high++;
    else cur_high = 0;
    if (m_done === 1'b1) total_done++;
    prev_cs  = m_cs;
    prev_scl = m_scl;
  end

  int checks = 0, errors = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic kick(input logic [7:0] tx);
    @(negedge clk);
    start   = 1'b1;
    tx_data = tx;
    @(negedge clk);
    start   = 1'b0;
    tx_data = ~tx;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (m_done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check1({tag, "_done_seen"}, m_done, 1'b1);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] slv;
    bit         loop;
    bit         d1;
    logic [7:0] exp_rx;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int r0, d0, dv;
    dv       = v.d1 ? 1 : 2;
    sel      = v.d1;
    loop     = v.loop;
    slv_byte = v.slv;
    r0       = total_rises;
    d0       = total_done;
    kick(v.tx);
    check1({tag, "_busy_on"}, m_busy, 1'b1);
    check1({tag, "_cs_low"}, m_cs, 1'b0);
    check1({tag, "_mosi_msb"}, m_mosi, v.tx[7]);
    wait_done(tag);
    check8({tag, "_rx"}, m_rx, v.exp_rx);
    check1({tag, "_busy_in_done"}, m_busy, 1'b0);
    @(negedge clk);
    check1({tag, "_done_pulse_len"}, m_done, 1'b0);
    @(negedge clk);
    checki({tag, "_done_count"}, total_done - d0, 1);
    checki({tag, "_scl_rises"}, total_rises - r0, 8);
    check8({tag, "_mosi_bits"}, cap, v.tx);
    checki({tag, "_cs_low_len"}, last_low, 17 * dv);
    checki({tag, "_first_rise_gap"}, first_gap, dv);
    check1({tag, "_idle_cs"}, m_cs, 1'b1);
    check1({tag, "_idle_scl"}, m_scl, 1'b0);
    check1({tag, "_idle_mosi"}, m_mosi, 1'b0);
    check8({tag, "_rx_hold"}, m_rx, v.exp_rx);
  endtask

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, n;
    vecs[0] = '{tx: 8'hA5, slv: 8'h3C, loop: 1'b0, d1: 1'b0, exp_rx: 8'h3C};
    vecs[1] = '{tx: 8'hDA, slv: 8'h00, loop: 1'b1, d1: 1'b0, exp_rx: 8'hDA};
    vecs[2] = '{tx: 8'h5A, slv: 8'hC3, loop: 1'b0, d1: 1'b1, exp_rx: 8'hC3};
    vecs[3] = '{tx: 8'h00, slv: 8'hFF, loop: 1'b0, d1: 1'b0, exp_rx: 8'hFF};
    vecs[4] = '{tx: 8'hFF, slv: 8'h00, loop: 1'b0, d1: 1'b1, exp_rx: 8'h00};
    vecs[5] = '{tx: 8'h81, slv: 8'h7E, loop: 1'b1, d1: 1'b1, exp_rx: 8'h81};

    repeat (3) @(negedge clk);
    check1("reset_cs", cs0, 1'b1);
    check1("reset_scl", scl0, 1'b0);
    check1("reset_mosi", mosi0, 1'b0);
    check1("reset_busy", busy0, 1'b0);
    check1("reset_done", done0, 1'b0);
    check8("reset_rx", rx0, 8'h00);
    check1("reset_cs_d1", cs1, 1'b1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // start re-pulsed mid-transfer with a different byte
    sel = 1'b0; loop = 1'b0; slv_byte = 8'h69;
    d0 = total_done;
    kick(8'h96);
    repeat (9) @(negedge clk);
    start = 1'b1; tx_data = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore");
    check8("ignore_rx", m_rx, 8'h69);
    check8("ignore_mosi_bits", cap, 8'h96);
    repeat (40) @(negedge clk);
    checki("ignore_done_count", total_done - d0, 1);
    check1("ignore_busy_after", m_busy, 1'b0);

    // start held through the done cycle: second transfer follows immediately
    slv_byte = 8'h55;
    d0 = total_done;
    @(negedge clk);
    start = 1'b1; tx_data = 8'h3C;
    @(negedge clk);
    tx_data = 8'h81;
    wait_done("b2b_first");
    check8("b2b_first_rx", m_rx, 8'h55);
    check8("b2b_first_mosi_bits", cap, 8'h3C);
    slv_byte = 8'hE7;
    @(negedge clk);
    start = 1'b0;
    check1("b2b_second_cs", m_cs, 1'b0);
    check1("b2b_second_busy", m_busy, 1'b1);
    check8("b2b_rx_held", m_rx, 8'h55);
    wait_done("b2b_second");
    check8("b2b_second_rx", m_rx, 8'hE7);
    check8("b2b_second_mosi_bits", cap, 8'h81);
    checki("b2b_cs_high_gap", last_high, 1);
    repeat (3) @(negedge clk);
    checki("b2b_done_count", total_done - d0, 2);

    // asynchronous reset between the 3rd and 4th scl rise
    slv_byte = 8'h3C;
    d0 = total_done;
    kick(8'hA5);
    @(negedge clk);
    n = 0;
    while (xfer_rises < 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checki("areset_third_rise", xfer_rises, 3);
    #1 rst = 1'b1;
    #1;
    check1("areset_cs", m_cs, 1'b1);
    check1("areset_scl", m_scl, 1'b0);
    check1("areset_mosi", m_mosi, 1'b0);
    check1("areset_busy", m_busy, 1'b0);
    check8("areset_rx", m_rx, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    checki("areset_no_done", total_done - d0, 0);
    run_vec('{tx: 8'hC3, slv: 8'h99, loop: 1'b0, d1: 1'b0, exp_rx: 8'h99}, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI mode-0 (CPOL=0, CPHA=0) master for single-byte, full-duplex transfers. MSB first.
- Initiator end of the link served by spi_slave. Drives scl, cs and mosi into the slave, and captures miso from it.
- A local controller starts a transfer with a one-cycle start pulse. The block reports busy, a one-cycle done pulse and the received byte.

Parameters:
- DATA_W, 8, transfer width in bits; fixed at 8 for spi_slave compatibility.
- CLK_DIV, 2, scl half-period in clk cycles; legal range 1..255.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  transfer request; sampled on each clk rising edge.
- tx_data  input  DATA_W  byte to send; latched in the cycle start is accepted.
- rx_data  output  DATA_W  last received byte; valid from the done cycle until the next done.
- busy  output  1  high while a transfer is in progress.
- done  output  1  one-cycle pulse at the end of a transfer.
- scl  output  1  SPI serial clock; idles low.
- mosi  output  1  master-out serial data.
- miso  input  1  master-in serial data from the slave.
- cs  output  1  active-low chip select; idles high.

Behaviour:
- Reset (async, immediate, also mid-transfer):
  - cs=1, scl=0, mosi=0, busy=0, done=0, rx_data=0.
  - FSM to IDLE, internal counters cleared. Any transfer in progress is aborted with no done pulse.
- All outputs are registered. No combinational path from inputs to outputs.
- FSM states: IDLE, LEAD, HIGH, LOW, TAIL.
- IDLE:
  - cs=1, scl=0, mosi=0, busy=0.
  - start=1 at edge E0: latch tx_data into the shift register, clear the bit counter, go to LEAD.
  - After E0: cs=0, busy=1, mosi=tx_data[7].
- LEAD:
  - scl held low for CLK_DIV cycles (mosi setup time).
  - Exit to HIGH at edge E0+CLK_DIV.
- HIGH (bit i, i=0..7):
  - The edge entering HIGH sets scl=1 and samples miso into rx_shift[7-i]. This is the value present during the preceding low phase.
  - scl stays high for CLK_DIV cycles.
- LOW:
  - The edge entering LOW sets scl=0.
  - If i<7: mosi=tx bit (6-i), i increments, scl stays low for CLK_DIV cycles, then back to HIGH.
  - If i==7: go to TAIL; mosi holds bit 0.
- TAIL:
  - scl low, cs still low, for CLK_DIV cycles.
  - At edge E0+17*CLK_DIV: cs=1, busy=0, done=1 for exactly one cycle, rx_data=rx_shift. FSM returns to IDLE.
- Timing summary:
  - scl rising edges at E0+(2i+1)*CLK_DIV.
  - scl falling edges at E0+(2i+2)*CLK_DIV.
  - Exactly 8 rising edges per transfer.
  - cs low for 17*CLK_DIV cycles.
- start while busy=1: ignored; no effect on the current transfer; tx_data is not re-latched.
- start in the done cycle: FSM is already in IDLE, so start is accepted.
  - cs is high for exactly one cycle (the done cycle), then goes low for the new transfer.
  - rx_data of the finished transfer remains valid until the next done.
- Changes to tx_data after acceptance have no effect on the current transfer.
- miso is not sampled outside HIGH-entry edges. X on miso at other times must not affect outputs.

Test Plan:
1. Basic transfer, CLK_DIV=2, tx_data=8'hA5, slave model returns 8'h3C.
   -> mosi captured at scl rises = 1,0,1,0,0,1,0,1; 8 scl rises; cs low 34 cycles; done one cycle; rx_data=8'h3C; busy low after.
2. Loopback (miso tied to mosi), tx_data=8'hDA, CLK_DIV=2.
   -> rx_data=8'hDA; first scl rise 2 cycles after cs falls.
3. start pulsed again at cycle 10 of a transfer with tx_data=8'hFF.
   -> ignored; transfer completes with the original byte; exactly one done.
4. Back-to-back: start held high through the done cycle, second tx_data=8'h81.
   -> cs high exactly 1 cycle between transfers; second transfer sends 1,0,0,0,0,0,0,1.
5. Reset asserted asynchronously between the 3rd and 4th scl rise.
   -> cs=1, scl=0, mosi=0, busy=0, rx_data=0 immediately; no done pulse; next start runs a clean transfer.
6. CLK_DIV=1, tx_data=8'h5A, miso=8'hC3.
   -> scl toggles every clk; cs low 17 cycles; rx_data=8'hC3.
